mips_multicycle_ctrl: RTL

//  Multi-cycle MIPS main control FSM. Sequences fetch/decode/execute/mem/writeback and drives datapath selects.

---
 rtl/mips_pkg.sv | 52 +++++
 rtl/mips_multicycle_ctrl_if.sv | 38 +++
 rtl/mips_alu_decode.sv | 49 ++++
 rtl/mips_multicycle_ctrl.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, functs,
// FSM states and the datapath select codes.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  localparam logic [3:0] ALU_AND   = 4'd0;
  localparam logic [3:0] ALU_OR    = 4'd1;
  localparam logic [3:0] ALU_ADD   = 4'd2;
  localparam logic [3:0] ALU_SUB   = 4'd6;
  localparam logic [3:0] ALU_SLT   = 4'd7;
  localparam logic [3:0] ALU_PASSB = 4'd8;

  localparam logic [1:0] EXT_SIGN = 2'd0;
  localparam logic [1:0] EXT_ZERO = 2'd1;
  localparam logic [1:0] EXT_LUI  = 2'd2;

  localparam logic [1:0] SRCB_RT     = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMMSH2 = 2'd3;

  localparam logic [1:0] PC_ALU    = 2'd0;
  localparam logic [1:0] PC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXR    = 4'd6,  S_RWB    = 4'd7,
    S_EXI    = 4'd8,  S_IWB    = 4'd9,  S_BRANCH = 4'd10, S_JUMP   = 4'd11,
    S_TRAP   = 4'd12
  } ctrlState;

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Controller <-> datapath/memory signal bundle. master = controller side.
interface mips_multicycle_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic             alu_zero;
  logic             mem_ready;
  logic             mem_read;
  logic             mem_write;
  logic             iord;
  logic             ir_write;
  logic             pc_en;
  logic [1:0]       pc_src;
  logic             reg_write;
  logic             reg_dst;
  logic             mem_to_reg;
  logic [1:0]       ext_sel;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [3:0]       alu_ctl;
  logic             illegal;
  logic [CNT_W-1:0] retired;

  modport master (
    input  opcode, funct, alu_zero, mem_ready,
    output mem_read, mem_write, iord, ir_write, pc_en, pc_src, reg_write,
           reg_dst, mem_to_reg, ext_sel, alu_src_a, alu_src_b, alu_ctl,
           illegal, retired
  );

  modport slave (
    output opcode, funct, alu_zero, mem_ready,
    input  mem_read, mem_write, iord, ir_write, pc_en, pc_src, reg_write,
           reg_dst, mem_to_reg, ext_sel, alu_src_a, alu_src_b, alu_ctl,
           illegal, retired
  );
endinterface

// File: rtl/mips_alu_decode.sv
// Combinational ALU-operation and immediate-extension select for the current
// state, plus a flag telling whether an R-type funct is one we implement.
module mips_alu_decode
  import mips_pkg::*;
(
  input  ctrlState   state,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [3:0] aluCtl,
  output logic [1:0] extSel,
  output logic       functOk
);

  logic [3:0] functAlu;

  always_comb begin
    functAlu = ALU_ADD;
    functOk  = 1'b1;
    case (funct)
      FN_ADD, FN_ADDU: functAlu = ALU_ADD;
      FN_SUB, FN_SUBU: functAlu = ALU_SUB;
      FN_AND:          functAlu = ALU_AND;
      FN_OR:           functAlu = ALU_OR;
      FN_SLT:          functAlu = ALU_SLT;
      default:         functOk  = 1'b0;
    endcase
  end

  // Address/target computations elsewhere all use add with a sign-extended immediate.
  always_comb begin
    aluCtl = ALU_ADD;
    extSel = EXT_SIGN;
    case (state)
      S_EXR:    aluCtl = functAlu;
      S_BRANCH: aluCtl = ALU_SUB;
      S_EXI: begin
        case (opcode)
          OP_SLTI: aluCtl = ALU_SLT;
          OP_ANDI: begin aluCtl = ALU_AND;   extSel = EXT_ZERO; end
          OP_ORI:  begin aluCtl = ALU_OR;    extSel = EXT_ZERO; end
          OP_LUI:  begin aluCtl = ALU_PASSB; extSel = EXT_LUI;  end
          default: aluCtl = ALU_ADD;
        endcase
      end
      default: aluCtl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS main control FSM: state register, retired-instruction
// counter and per-state datapath select decode.
module mips_multicycle_ctrl
  import mips_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  mips_multicycle_ctrl_if.master bus
);

  ctrlState         stateReg, stateNext;
  logic [CNT_W-1:0] retiredReg;
  logic             retire;
  logic [3:0]       aluCtl;
  logic [1:0]       extSel;
  logic             functOk;
  logic             memRead, memWrite, iord, irWrite, pcEn;
  logic             regWrite, regDst, memToReg, aluSrcA;
  logic [1:0]       pcSrc, aluSrcB;

  mips_alu_decode u_aluDecode (
    .state   (stateReg),
    .opcode  (bus.opcode),
    .funct   (bus.funct),
    .aluCtl  (aluCtl),
    .extSel  (extSel),
    .functOk (functOk)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateReg   <= S_FETCH;
      retiredReg <= '0;
    end else begin
      stateReg <= stateNext;
      if (retire) retiredReg <= retiredReg + CNT_W'(1);
    end
  end

  always_comb begin
    stateNext = stateReg;
    memRead   = 1'b0;
    memWrite  = 1'b0;
    iord      = 1'b0;
    irWrite   = 1'b0;
    pcEn      = 1'b0;
    pcSrc     = PC_ALU;
    regWrite  = 1'b0;
    regDst    = 1'b0;
    memToReg  = 1'b0;
    aluSrcA   = 1'b0;
    aluSrcB   = SRCB_RT;
    case (stateReg)
      S_FETCH: begin
        memRead = 1'b1;
        aluSrcB = SRCB_FOUR;
        irWrite = bus.mem_ready;
        pcEn    = bus.mem_ready;
        if (bus.mem_ready) stateNext = S_DECODE;
      end
      S_DECODE: begin
        aluSrcB = SRCB_IMMSH2;
        case (bus.opcode)
          OP_LW, OP_SW:                             stateNext = S_MEMADR;
          OP_RTYPE:                                 stateNext = S_EXR;
          OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI: stateNext = S_EXI;
          OP_BEQ, OP_BNE:                           stateNext = S_BRANCH;
          OP_J:                                     stateNext = S_JUMP;
          default:                                  stateNext = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        aluSrcA   = 1'b1;
        aluSrcB   = SRCB_IMM;
        stateNext = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        memRead = 1'b1;
        iord    = 1'b1;
        if (bus.mem_ready) stateNext = S_MEMWB;
      end
      S_MEMWB: begin
        regWrite  = 1'b1;
        memToReg  = 1'b1;
        stateNext = S_FETCH;
      end
      S_MEMWR: begin
        memWrite = 1'b1;
        iord     = 1'b1;
        if (bus.mem_ready) stateNext = S_FETCH;
      end
      S_EXR: begin
        aluSrcA   = 1'b1;
        stateNext = functOk ? S_RWB : S_TRAP;
      end
      S_RWB: begin
        regWrite  = 1'b1;
        regDst    = 1'b1;
        stateNext = S_FETCH;
      end
      S_EXI: begin
        aluSrcA   = 1'b1;
        aluSrcB   = SRCB_IMM;
        stateNext = S_IWB;
      end
      S_IWB: begin
        regWrite  = 1'b1;
        stateNext = S_FETCH;
      end
      S_BRANCH: begin
        aluSrcA   = 1'b1;
        pcSrc     = PC_ALUOUT;
        pcEn      = (bus.opcode == OP_BEQ) ? bus.alu_zero : ~bus.alu_zero;
        stateNext = S_FETCH;
      end
      S_JUMP: begin
        pcSrc     = PC_JUMP;
        pcEn      = 1'b1;
        stateNext = S_FETCH;
      end
      default: stateNext = S_TRAP;
    endcase
    // FETCH is only ever re-entered from a completing state, so entry == retire.
    retire = (stateNext == S_FETCH) && (stateReg != S_FETCH);
  end

  // Write-type enables are held off while reset is asserted.
  assign bus.mem_read   = memRead;
  assign bus.mem_write  = memWrite & ~reset;
  assign bus.iord       = iord;
  assign bus.ir_write   = irWrite & ~reset;
  assign bus.pc_en      = pcEn & ~reset;
  assign bus.pc_src     = pcSrc;
  assign bus.reg_write  = regWrite & ~reset;
  assign bus.reg_dst    = regDst;
  assign bus.mem_to_reg = memToReg;
  assign bus.ext_sel    = extSel;
  assign bus.alu_src_a  = aluSrcA;
  assign bus.alu_src_b  = aluSrcB;
  assign bus.alu_ctl    = aluCtl;
  assign bus.illegal    = (stateReg == S_TRAP);
  assign bus.retired    = retiredReg;

endmodule
